// File: rtl/pong_ball_pkg.sv
// Shared definitions for the PONG ball engine: screen defaults, FSM encoding,
// centre position and score helpers.
package pong_ball_pkg;

  localparam int H_PIXELS_DEF = 640;
  localparam int V_PIXELS_DEF = 480;

  // Top-left corner of a centred 8x8 ball on the default screen.
  localparam int CENTRE_X = 316;
  localparam int CENTRE_Y = 236;

  localparam logic [3:0] SCORE_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_ball_collide.sv
// Horizontal collision resolver: next x, next direction and miss flag from the
// current ball position and both paddle tops. Purely combinational.
module pong_ball_collide
  import pong_ball_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int BALL     = 8,
  parameter int SPEED    = 2,
  parameter int PADDLE_H = 64,
  parameter int PADDLE_W = 8,
  parameter int PLX      = 16,
  parameter int PRX      = 616
) (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       dx_right,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] next_x,
  output logic       next_dx_right,
  output logic       miss
);

  localparam logic [10:0] B      = 11'(BALL);
  localparam logic [10:0] S      = 11'(SPEED);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] HP     = 11'(H_PIXELS);
  localparam logic [10:0] PR     = 11'(PRX);
  localparam logic [10:0] PL_END = 11'(PLX + PADDLE_W);
  localparam logic [9:0]  S10    = 10'(SPEED);
  localparam logic [9:0]  R_STOP = 10'(PRX - BALL);
  localparam logic [9:0]  L_STOP = 10'(PLX + PADDLE_W);

  // 11-bit intermediates so that sums such as x+BALL+SPEED never wrap.
  logic [10:0] x, y, pl, pr;
  logic        overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

  assign x  = {1'b0, ball_x};
  assign y  = {1'b0, ball_y};
  assign pl = {1'b0, paddle_l_y};
  assign pr = {1'b0, paddle_r_y};

  assign overlap_l = (y + B > pl) && (y < pl + PH);
  assign overlap_r = (y + B > pr) && (y < pr + PH);

  assign hit_r  = (x + B <= PR) && (x + B + S > PR) && overlap_r;
  assign miss_r = (x + B + S > HP);
  assign hit_l  = (x >= PL_END) && (x < PL_END + S) && overlap_l;
  assign miss_l = (x < S);

  // NOTE: every output gets a default before the branches so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_x        = ball_x;
    next_dx_right = dx_right;
    miss          = 1'b0;
    if (dx_right) begin
      if (hit_r) begin
        next_x        = R_STOP;
        next_dx_right = 1'b0;
      end else if (miss_r) begin
        miss          = 1'b1;
        next_dx_right = 1'b1;
      end else begin
        next_x = ball_x + S10;
      end
    end else begin
      if (hit_l) begin
        next_x        = L_STOP;
        next_dx_right = 1'b1;
      end else if (miss_l) begin
        miss          = 1'b1;
        next_dx_right = 1'b0;
      end else begin
        next_x = ball_x - S10;
      end
    end
  end

endmodule

// File: rtl/pong_ball.sv
// PONG ball engine: advances the ball once per frame, resolves walls, paddles
// and misses, keeps scores and flags the beam being on the ball.
module pong_ball
  import pong_ball_pkg::*;
#(
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int V_PIXELS     = V_PIXELS_DEF,
  parameter int BALL         = 8,
  parameter int SPEED        = 2,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PLX          = 16,
  parameter int PRX          = 616,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       vga_clock,
  input  logic       rst,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  input  logic       dsp_en,
  input  logic       end_of_frame,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  input  logic       serve,
  output logic       ball_pixel,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       score_l_pulse,
  output logic       score_r_pulse,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int          CW         = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_FRAMES - 1);
  localparam logic [10:0] B11      = 11'(BALL);
  localparam logic [10:0] S11      = 11'(SPEED);
  localparam logic [10:0] VP11     = 11'(V_PIXELS);
  localparam logic [9:0]  S10      = 10'(SPEED);
  localparam logic [9:0]  Y_BOTTOM = 10'(V_PIXELS - BALL);
  localparam logic [9:0]  CX       = 10'(CENTRE_X);
  localparam logic [9:0]  CY       = 10'(CENTRE_Y);

  state_t        state, state_next;
  logic          dx_right, dx_right_next, dy_down, dy_down_next;
  logic [9:0]    x_next, y_next, y_vert, col_x;
  logic          dy_vert, col_dx_right, col_miss;
  logic [CW-1:0] pause_cnt, pause_cnt_next;
  logic [3:0]    score_l_next, score_r_next;
  logic          pulse_l_next, pulse_r_next, pixel_next;
  logic [10:0]   y11, bx11, by11, vx11, vy11;

  pong_ball_collide #(
    .H_PIXELS (H_PIXELS),
    .BALL     (BALL),
    .SPEED    (SPEED),
    .PADDLE_H (PADDLE_H),
    .PADDLE_W (PADDLE_W),
    .PLX      (PLX),
    .PRX      (PRX)
  ) u_collide (
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .dx_right      (dx_right),
    .paddle_l_y    (paddle_l_y),
    .paddle_r_y    (paddle_r_y),
    .next_x        (col_x),
    .next_dx_right (col_dx_right),
    .miss          (col_miss)
  );

  assign game_over = (score_l == SCORE_MAX) || (score_r == SCORE_MAX);

  assign y11  = {1'b0, ball_y};
  assign bx11 = {1'b0, ball_x};
  assign by11 = y11;
  assign vx11 = {1'b0, vga_x};
  assign vy11 = {1'b0, vga_y};

  // Vertical wall bounce, independent of the horizontal resolver.
  always_comb begin
    y_vert  = ball_y + S10;
    dy_vert = dy_down;
    if (dy_down) begin
      if (y11 + B11 + S11 > VP11) begin
        y_vert  = Y_BOTTOM;
        dy_vert = 1'b0;
      end
    end else if (y11 < S11) begin
      y_vert  = '0;
      dy_vert = 1'b1;
    end else begin
      y_vert = ball_y - S10;
    end
  end

  always_comb begin
    state_next     = state;
    x_next         = ball_x;
    y_next         = ball_y;
    dx_right_next  = dx_right;
    dy_down_next   = dy_down;
    pause_cnt_next = pause_cnt;
    score_l_next   = score_l;
    score_r_next   = score_r;
    pulse_l_next   = 1'b0;
    pulse_r_next   = 1'b0;
    case (state)
      IDLE: begin
        if (serve && !game_over) state_next = MOVE;
      end
      MOVE: begin
        if (end_of_frame) begin
          x_next        = col_x;
          y_next        = y_vert;
          dx_right_next = col_dx_right;
          dy_down_next  = dy_vert;
          if (col_miss) begin
            state_next     = PAUSE;
            pause_cnt_next = '0;
            // Ball leaving on the right means the left player scored.
            if (dx_right) begin
              score_l_next = sat_inc(score_l);
              pulse_l_next = 1'b1;
            end else begin
              score_r_next = sat_inc(score_r);
              pulse_r_next = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (end_of_frame) begin
          if (pause_cnt == PAUSE_LAST) begin
            state_next     = IDLE;
            x_next         = CX;
            y_next         = CY;
            dy_down_next   = !dy_down;
            pause_cnt_next = '0;
          end else begin
            pause_cnt_next = pause_cnt + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pixel_next = dsp_en && (state != PAUSE) &&
                      (vx11 >= bx11) && (vx11 < bx11 + B11) &&
                      (vy11 >= by11) && (vy11 < by11 + B11);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge vga_clock or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ball_x        <= CX;
      ball_y        <= CY;
      dx_right      <= 1'b1;
      dy_down       <= 1'b1;
      pause_cnt     <= '0;
      score_l       <= '0;
      score_r       <= '0;
      score_l_pulse <= 1'b0;
      score_r_pulse <= 1'b0;
      ball_pixel    <= 1'b0;
    end else begin
      state         <= state_next;
      ball_x        <= x_next;
      ball_y        <= y_next;
      dx_right      <= dx_right_next;
      dy_down       <= dy_down_next;
      pause_cnt     <= pause_cnt_next;
      score_l       <= score_l_next;
      score_r       <= score_r_next;
      score_l_pulse <= pulse_l_next;
      score_r_pulse <= pulse_r_next;
      ball_pixel    <= pixel_next;
    end
  end

endmodule

// File: tb/tb_pong_ball.sv
// Self-checking bench for pong_ball: randomized beam and paddles, a frame-level
// reference model feeding a scoreboard queue, and directed milestone checks.
module tb_pong_ball;

  localparam int FRAME_LEN  = 6;
  localparam int BALL       = 8;
  localparam int SPEED      = 2;
  localparam int PADDLE_H   = 64;
  localparam int PLX_END    = 24;
  localparam int PRX        = 616;
  localparam int H_PIXELS   = 640;
  localparam int V_PIXELS   = 480;
  localparam int PAUSE_LEN  = 60;
  localparam int PAD_RANDOM = -1;
  localparam int PAD_TRACK  = -2;
  localparam int SV_LOW     = 0;
  localparam int SV_PULSE   = 1;
  localparam int SV_HIGH    = 2;
  localparam int SV_RAND    = 3;

  logic       vga_clock = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] vga_x = '0, vga_y = '0;
  logic       dsp_en = 1'b0, end_of_frame = 1'b0, serve = 1'b0;
  logic [9:0] paddle_l_y = '0, paddle_r_y = '0;
  logic       ball_pixel, score_l_pulse, score_r_pulse, game_over;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_l, score_r;

  pong_ball dut (
    .vga_clock     (vga_clock),
    .rst           (rst),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .dsp_en        (dsp_en),
    .end_of_frame  (end_of_frame),
    .paddle_l_y    (paddle_l_y),
    .paddle_r_y    (paddle_r_y),
    .serve         (serve),
    .ball_pixel    (ball_pixel),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .score_l_pulse (score_l_pulse),
    .score_r_pulse (score_r_pulse),
    .score_l       (score_l),
    .score_r       (score_r),
    .game_over     (game_over)
  );

  always #20 vga_clock = ~vga_clock;

  typedef struct {
    int bx, by, pix, sl, sr, pl, pr, go;
  } exp_t;

  typedef enum int {M_IDLE, M_MOVE, M_PAUSE} mode_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: ball position, directions as +1/-1, scores, pause frames.
  int    mx, my, mdx, mdy, msl, msr, mcnt, mpix, mpl, mpr;
  mode_t mmode;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic bit overlaps(input int y, input int p);
    return (y + BALL > p) && (y < p + PADDLE_H);
  endfunction

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1;
    msl = 0; msr = 0; mcnt = 0;
    mpix = 0; mpl = 0; mpr = 0;
    mmode = M_IDLE;
  endtask

  task automatic model_step(input bit r, input int vx, input int vy, input bit de,
                            input bit eof, input bit sv, input int pl, input int pr);
    int nx, ny, ndy;
    if (r) begin
      model_reset();
      return;
    end
    mpix = (de && mmode != M_PAUSE && vx >= mx && vx < mx + BALL &&
            vy >= my && vy < my + BALL) ? 1 : 0;
    mpl = 0;
    mpr = 0;
    case (mmode)
      M_IDLE: if (sv && msl != 9 && msr != 9) mmode = M_MOVE;
      M_MOVE: if (eof) begin
        ndy = mdy;
        if (mdy > 0) begin
          if (my + BALL + SPEED > V_PIXELS) begin ny = V_PIXELS - BALL; ndy = -1; end
          else ny = my + SPEED;
        end else begin
          if (my < SPEED) begin ny = 0; ndy = 1; end
          else ny = my - SPEED;
        end
        nx = mx;
        if (mdx > 0) begin
          if (mx + BALL <= PRX && mx + BALL + SPEED > PRX && overlaps(my, pr)) begin
            nx = PRX - BALL; mdx = -1;
          end else if (mx + BALL + SPEED > H_PIXELS) begin
            msl = (msl < 9) ? msl + 1 : 9; mpl = 1; mmode = M_PAUSE; mcnt = 0;
          end else nx = mx + SPEED;
        end else begin
          if (mx >= PLX_END && mx < PLX_END + SPEED && overlaps(my, pl)) begin
            nx = PLX_END; mdx = 1;
          end else if (mx < SPEED) begin
            msr = (msr < 9) ? msr + 1 : 9; mpr = 1; mmode = M_PAUSE; mcnt = 0;
          end else nx = mx - SPEED;
        end
        mx = nx; my = ny; mdy = ndy;
      end
      M_PAUSE: if (eof) begin
        mcnt++;
        if (mcnt == PAUSE_LEN) begin
          mx = 316; my = 236; mdy = -mdy; mmode = M_IDLE;
        end
      end
      default: mmode = M_IDLE;
    endcase
  endtask

  // One clock of stimulus; the expected outputs after the next edge are queued.
  task automatic drive_cycle(input bit eof, input bit sv, input int pl, input int pr,
                             input bit r);
    int   vx, vy;
    bit   de;
    exp_t e;
    @(posedge vga_clock);
    #2;
    if ($urandom_range(0, 1) == 1) begin
      vx = mx + int'($urandom_range(0, 11)) - 2;
      vy = my + int'($urandom_range(0, 11)) - 2;
      if (vx < 0) vx = 0;
      if (vy < 0) vy = 0;
    end else begin
      vx = int'($urandom_range(0, 1023));
      vy = int'($urandom_range(0, 1023));
    end
    de = ($urandom_range(0, 3) != 0);
    rst          = r;
    vga_x        = 10'(vx);
    vga_y        = 10'(vy);
    dsp_en       = de;
    end_of_frame = eof;
    serve        = sv;
    paddle_l_y   = 10'(pl);
    paddle_r_y   = 10'(pr);
    model_step(r, vx, vy, de, eof, sv, pl, pr);
    e.bx = mx; e.by = my; e.pix = mpix; e.sl = msl; e.sr = msr;
    e.pl = mpl; e.pr = mpr; e.go = (msl == 9 || msr == 9) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  // One compressed frame: eof on its first cycle.
  task automatic run_frame(input int sv_mode, input int pl_mode, input int pr_mode);
    int pl_rand, pr_rand, pl, pr;
    bit sv;
    pl_rand = int'($urandom_range(0, 480));
    pr_rand = int'($urandom_range(0, 480));
    for (int c = 0; c < FRAME_LEN; c++) begin
      pl = (pl_mode == PAD_RANDOM) ? pl_rand : (pl_mode == PAD_TRACK) ? my : pl_mode;
      pr = (pr_mode == PAD_RANDOM) ? pr_rand : (pr_mode == PAD_TRACK) ? my : pr_mode;
      case (sv_mode)
        SV_PULSE: sv = (c == 0);
        SV_HIGH:  sv = 1'b1;
        SV_RAND:  sv = ($urandom_range(0, 1) == 1);
        default:  sv = 1'b0;
      endcase
      drive_cycle(c == 0, sv, pl, pr, 1'b0);
    end
  endtask

  // Monitor: every cycle the DUT presents a new output set; compare with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_ball_x",        int'(ball_x),        e.bx);
        check("sb_ball_y",        int'(ball_y),        e.by);
        check("sb_ball_pixel",    int'(ball_pixel),    e.pix);
        check("sb_score_l",       int'(score_l),       e.sl);
        check("sb_score_r",       int'(score_r),       e.sr);
        check("sb_score_l_pulse", int'(score_l_pulse), e.pl);
        check("sb_score_r_pulse", int'(score_r_pulse), e.pr);
        check("sb_game_over",     int'(game_over),     e.go);
      end
    end
  end

  initial begin
    #(64'd40 * 64'd100000);
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_r;
    model_reset();
    repeat (3) drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
    repeat (4) drive_cycle(1'b0, 1'b0, 0, 0, 1'b0);
    check("reset_ball_x", int'(ball_x), 316);
    check("reset_ball_y", int'(ball_y), 236);
    check("reset_score_l", int'(score_l), 0);
    check("reset_score_r", int'(score_r), 0);
    check("reset_game_over", int'(game_over), 0);

    // IDLE without serve: eofs do not move the ball.
    repeat (3) run_frame(SV_LOW, PAD_RANDOM, PAD_RANDOM);
    check("idle_still_x", int'(ball_x), 316);

    // Round 1: right paddle out of the way, left player scores on eof 159.
    run_frame(SV_PULSE, PAD_RANDOM, 0);
    check("serve_eof_no_move", int'(ball_x), 316);
    for (int k = 1; k <= 159; k++) begin
      run_frame(SV_LOW, PAD_RANDOM, 0);
      if (k == 1)   begin check("eof1_x", int'(ball_x), 318); check("eof1_y", int'(ball_y), 238); end
      if (k == 118) check("wall_eof118_y", int'(ball_y), 472);
      if (k == 119) check("wall_eof119_y", int'(ball_y), 472);
      if (k == 120) check("wall_eof120_y", int'(ball_y), 470);
      if (k == 159) begin
        check("miss_score_l", int'(score_l), 1);
        check("miss_score_r", int'(score_r), 0);
      end
    end
    for (int k = 160; k <= 159 + PAUSE_LEN; k++) begin
      run_frame(SV_LOW, PAD_RANDOM, PAD_RANDOM);
      if (k == 158 + PAUSE_LEN) check("pause_last_frame_x", int'(ball_x), 632);
    end
    check("recentre_x", int'(ball_x), 316);
    check("recentre_y", int'(ball_y), 236);

    // Round 2: right paddle at 400 catches the ball at x=608.
    run_frame(SV_PULSE, PAD_RANDOM, 400);
    for (int k = 1; k <= 148; k++) begin
      run_frame(SV_LOW, PAD_RANDOM, 400);
      if (k == 118) check("r2_wall_y", int'(ball_y), 472);
      if (k == 146) check("hit_eof146_x", int'(ball_x), 608);
      if (k == 147) check("hit_eof147_x", int'(ball_x), 608);
      if (k == 148) check("hit_eof148_x", int'(ball_x), 606);
    end
    repeat (200) run_frame(SV_LOW, PAD_RANDOM, 400);

    // Free play with random serve and paddles.
    repeat (400) run_frame(SV_RAND, PAD_RANDOM, PAD_RANDOM);

    // Force a right-player point: right paddle tracks, left paddle absent.
    start_r = msr;
    for (int f = 0; f < 600 && msr == start_r; f++) run_frame(SV_HIGH, 1000, PAD_TRACK);
    check("right_point", int'(score_r), start_r + 1);

    // Left player scores until saturation.
    for (int f = 0; f < 3000 && msl < 9; f++) run_frame(SV_HIGH, PAD_TRACK, 1000);
    repeat (70) run_frame(SV_HIGH, PAD_TRACK, 1000);
    check("game_over_set", int'(game_over), 1);
    check("score_l_saturated", int'(score_l), 9);
    check("serve_ignored_x", int'(ball_x), 316);
    check("serve_ignored_y", int'(ball_y), 236);

    // Mid-frame reset: outputs return to reset values without waiting for an edge.
    drive_cycle(1'b0, 1'b1, 0, 0, 1'b0);
    drive_cycle(1'b0, 1'b1, 0, 0, 1'b1);
    #1;
    check("rst_ball_x", int'(ball_x), 316);
    check("rst_ball_y", int'(ball_y), 236);
    check("rst_score_l", int'(score_l), 0);
    check("rst_score_r", int'(score_r), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_ball_pixel", int'(ball_pixel), 0);
    check("rst_pulse_l", int'(score_l_pulse), 0);
    check("rst_pulse_r", int'(score_r_pulse), 0);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b0);
    run_frame(SV_PULSE, PAD_RANDOM, PAD_RANDOM);
    run_frame(SV_LOW, PAD_RANDOM, PAD_RANDOM);
    check("post_rst_eof1_x", int'(ball_x), 318);

    repeat (2) @(posedge vga_clock);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
